// File: rtl/dm_store_buffer_pkg.sv
// Shared types for the data-memory store buffer: buffer entry layout and byte-enable codes
// used by both the buffer and the MEM-stage store aligner.
package dm_store_buffer_pkg;

  localparam int STBUF_DEPTH = 4;

  typedef enum logic [3:0] {
    BE_NONE  = 4'b0000,
    BE_BYTE0 = 4'b0001,
    BE_BYTE1 = 4'b0010,
    BE_BYTE2 = 4'b0100,
    BE_BYTE3 = 4'b1000,
    BE_HALF0 = 4'b0011,
    BE_HALF1 = 4'b1100,
    BE_WORD  = 4'b1111
  } be_code_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] pc;
  } entry_t;

endpackage

// File: rtl/dm_store_buffer_if.sv
// MEM-stage store/load handshake plus the single data-memory port owned by the store buffer.
interface dm_store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_wd;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [31:0] dm_rd;

  modport master (
    output st_valid, st_addr, st_wd, st_be, st_pc, ld_valid, ld_addr, dm_rd,
    input  st_ready, ld_ready, ld_data, dm_addr, dm_we, dm_wd, dm_pc
  );

  modport slave (
    input  st_valid, st_addr, st_wd, st_be, st_pc, ld_valid, ld_addr, dm_rd,
    output st_ready, ld_ready, ld_data, dm_addr, dm_we, dm_wd, dm_pc
  );
endinterface

// File: rtl/dm_store_buffer_merge.sv
// Byte-lane merge: each enabled lane of wd replaces the same lane of base.
module dm_store_buffer_merge (
  input  logic [31:0] base,
  input  logic [31:0] wd,
  input  logic [3:0]  be,
  output logic [31:0] merged
);
  always_comb begin
    // NOTE: default every output bit first so a disabled lane can never infer a latch.
    merged = base;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
    end
  end
endmodule

// File: rtl/dm_store_buffer.sv
// Store buffer between MEM and data memory: FIFO of byte-enabled stores drained by
// read-merge-write. Define STBUF_FWD_EN to forward buffered bytes to loads; otherwise loads
// that hit a buffered word stall until those entries drain.
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = STBUF_DEPTH,
  parameter int PTR_W = 2
) (
  input logic              clk,
  input logic              reset,
  dm_store_buffer_if.slave bus
);

  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

  entry_t             mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [PTR_W-1:0]   head, tail;
  logic [PTR_W:0]     count;
  logic               full, push, drain_go;
  logic [31:0]        drain_wd;
  logic [DEPTH-1:0]   hit;
  logic [PTR_W-1:0]   slot [DEPTH];

  // count never exceeds DEPTH = 2**PTR_W, so its MSB alone marks the full state.
  assign full         = count[PTR_W];
  assign push         = bus.st_valid && !full;
  assign bus.st_ready = !full;

  // slot[g] is the g-th oldest entry; hit marks valid entries in the load's word.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign slot[g] = head + PTR_W'(g);
    assign hit[g]  = valid[slot[g]] && (mem[slot[g]].addr[31:2] == bus.ld_addr[31:2]);
  end

`ifdef STBUF_FWD_EN
  logic [31:0] chain [DEPTH+1];

  assign chain[0] = bus.dm_rd;
  for (genvar g = 0; g < DEPTH; g++) begin : g_fwd
    dm_store_buffer_merge u_fwd_merge (
      .base   (chain[g]),
      .wd     (mem[slot[g]].wd),
      .be     (hit[g] ? mem[slot[g]].be : BE_NONE),
      .merged (chain[g+1])
    );
  end

  assign bus.ld_ready = !full;
  assign bus.ld_data  = chain[DEPTH];
`else
  assign bus.ld_ready = !full && (hit == '0);
  assign bus.ld_data  = bus.dm_rd;
`endif

  // A ready load owns the DM port; the head drains on any other cycle.
  assign drain_go = (count != '0) && (!bus.ld_valid || !bus.ld_ready);

  dm_store_buffer_merge u_drain_merge (
    .base   (bus.dm_rd),
    .wd     (mem[head].wd),
    .be     (mem[head].be),
    .merged (drain_wd)
  );

  assign bus.dm_we   = drain_go;
  assign bus.dm_addr = drain_go ? mem[head].addr : bus.ld_addr;
  assign bus.dm_wd   = drain_wd;
  assign bus.dm_pc   = mem[head].pc;

  // NOTE: entry payloads are not reset; the valid bits and count gate every use of them.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{addr: bus.st_addr, wd: bus.st_wd, be: bus.st_be, pc: bus.st_pc};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_ONE;
      end
      if (drain_go) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_ONE;
      end
      case ({push, drain_go})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
